// File: rtl/iq_alloc_ctrl.sv
// iq_alloc_ctrl: issue-queue dispatch gate and mispredict recovery walker; `IQ_STALL_CNT_EN adds a saturating stall counter
module iq_alloc_ctrl #(
  parameter int SIZE_ISSUEQ     = 32,
  parameter int SIZE_ISSUEQ_LOG = 5,
  parameter int DISPATCH_WIDTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       dispValid_i,
  output logic                       dispReady_o,
  input  logic [SIZE_ISSUEQ_LOG:0]   cntInstIssueQ_i,
  input  logic                       ctrlMispredict_i,
  input  logic [SIZE_ISSUEQ-1:0]     mispredictVector_i,
  output logic                       backEndReady_o,
  output logic [SIZE_ISSUEQ_LOG-1:0] reclaimEntry0_o,
  output logic [SIZE_ISSUEQ_LOG-1:0] reclaimEntry1_o,
  output logic [SIZE_ISSUEQ_LOG-1:0] reclaimEntry2_o,
  output logic [SIZE_ISSUEQ_LOG-1:0] reclaimEntry3_o,
  output logic                       reclaimValid0_o,
  output logic                       reclaimValid1_o,
  output logic                       reclaimValid2_o,
  output logic                       reclaimValid3_o,
  output logic                       recoverBusy_o,
  output logic [15:0]                stallCount_o
);
  typedef enum logic {RUN, RECOVER} state_t;
  localparam logic [SIZE_ISSUEQ_LOG:0] LP_LIMIT = (SIZE_ISSUEQ_LOG+1)'(SIZE_ISSUEQ - DISPATCH_WIDTH);
  state_t                     r_state, w_state_next;
  logic [SIZE_ISSUEQ-1:0]     r_mask, w_mask_next, w_sel;
  logic [SIZE_ISSUEQ_LOG-1:0] w_ent [4];
  logic [3:0]                 w_vld;
  logic [2:0]                 w_n;
  logic                       w_rec;
  assign w_rec          = r_state == RECOVER;
  assign dispReady_o    = ~reset & ~w_rec & ~ctrlMispredict_i & (cntInstIssueQ_i <= LP_LIMIT);
  assign backEndReady_o = dispValid_i & dispReady_o;
  assign recoverBusy_o  = w_rec;
  assign reclaimEntry0_o = w_ent[0];
  assign reclaimEntry1_o = w_ent[1];
  assign reclaimEntry2_o = w_ent[2];
  assign reclaimEntry3_o = w_ent[3];
  assign reclaimValid0_o = w_vld[0];
  assign reclaimValid1_o = w_vld[1];
  assign reclaimValid2_o = w_vld[2];
  assign reclaimValid3_o = w_vld[3];
  // pick the four lowest squashed entries, packed ascending from slot 0 (mask is always zero in RUN)
  always_comb begin
    w_sel = '0;
    w_vld = '0;
    w_n   = '0;
    for (int i = 0; i < 4; i++) w_ent[i] = '0;
    for (int i = 0; i < SIZE_ISSUEQ; i++)
      if (r_mask[i] && w_n < 3'd4) begin
        w_sel[i]          = 1'b1;
        w_ent[w_n[1:0]]   = i[SIZE_ISSUEQ_LOG-1:0];
        w_vld[w_n[1:0]]   = 1'b1;
        w_n               = w_n + 3'd1;
      end
  end
  // next state: mispredict in RUN latches the vector; RECOVER retires selected bits and merges new mispredicts
  always_comb begin
    w_state_next = r_state;
    w_mask_next  = r_mask;
    if (!w_rec) begin
      w_mask_next  = ctrlMispredict_i ? mispredictVector_i : r_mask;
      w_state_next = ctrlMispredict_i ? RECOVER : RUN;
    end else begin
      w_mask_next  = (r_mask & ~w_sel) | (ctrlMispredict_i ? mispredictVector_i : '0);
      w_state_next = |w_mask_next ? RECOVER : RUN;
    end
  end
  // state and squash mask registers; reset drops any pending reclaims
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= RUN;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
    end
`ifdef IQ_STALL_CNT_EN
  logic [15:0] r_stall;
  // count cycles where dispatch offers a bundle that cannot be accepted, saturating
  always_ff @(posedge clock or posedge reset)
    if (reset) r_stall <= '0;
    else if (dispValid_i && !dispReady_o && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
  assign stallCount_o = r_stall;
`else
  assign stallCount_o = '0;
`endif
endmodule

// File: tb/tb_iq_alloc_ctrl.sv
// tb_iq_alloc_ctrl: directed and randomized check of iq_alloc_ctrl against a queue-based reference model
module tb_iq_alloc_ctrl;
  logic        clock = 0, reset = 1, dispValid_i = 1, ctrlMispredict_i = 0;
  logic [5:0]  cntInstIssueQ_i = 0;
  logic [31:0] mispredictVector_i = 0;
  logic        dispReady_o, backEndReady_o, recoverBusy_o;
  logic [4:0]  e0, e1, e2, e3;
  logic        v0, v1, v2, v3;
  logic [15:0] stallCount_o;
  logic [4:0]  a_e [4];
  logic [3:0]  a_v;
  int errs = 0, checks = 0;
  bit m_rec = 0;
  int m_q[$];
  int m_stall = 0;

  iq_alloc_ctrl dut (
    .clock(clock), .reset(reset), .dispValid_i(dispValid_i), .dispReady_o(dispReady_o),
    .cntInstIssueQ_i(cntInstIssueQ_i), .ctrlMispredict_i(ctrlMispredict_i),
    .mispredictVector_i(mispredictVector_i), .backEndReady_o(backEndReady_o),
    .reclaimEntry0_o(e0), .reclaimEntry1_o(e1), .reclaimEntry2_o(e2), .reclaimEntry3_o(e3),
    .reclaimValid0_o(v0), .reclaimValid1_o(v1), .reclaimValid2_o(v2), .reclaimValid3_o(v3),
    .recoverBusy_o(recoverBusy_o), .stallCount_o(stallCount_o)
  );

  assign a_e[0] = e0;
  assign a_e[1] = e1;
  assign a_e[2] = e2;
  assign a_e[3] = e3;
  assign a_v = {v3, v2, v1, v0};

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit has(int v);
    foreach (m_q[k]) if (m_q[k] == v) return 1;
    return 0;
  endfunction

  // reference model: pending squashed entries kept as a sorted set; checked then advanced every negedge
  always @(negedge clock) begin : cmp
    bit rdy;
    int n;
    if (reset) begin
      m_rec = 0;
      m_q.delete();
      m_stall = 0;
    end
    rdy = !reset && !m_rec && cntInstIssueQ_i <= 28 && !ctrlMispredict_i;
    n = (m_rec && !reset) ? (m_q.size() < 4 ? m_q.size() : 4) : 0;
    chk("dispReady", dispReady_o, rdy);
    chk("backEndReady", backEndReady_o, rdy && dispValid_i);
    chk("recoverBusy", recoverBusy_o, m_rec && !reset);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("valid%0d", i), a_v[i], i < n);
      chk($sformatf("entry%0d", i), a_e[i], i < n ? m_q[i] : 0);
    end
`ifdef IQ_STALL_CNT_EN
    chk("stallCount", stallCount_o, m_stall);
`else
    chk("stallCount", stallCount_o, 0);
`endif
    if (!reset) begin
      if (dispValid_i && !rdy && m_stall < 65535) m_stall++;
      repeat (n) void'(m_q.pop_front());
      if (ctrlMispredict_i)
        for (int j = 0; j < 32; j++) if (mispredictVector_i[j] && !has(j)) m_q.push_back(j);
      m_q.sort();
      m_rec = m_rec ? (m_q.size() != 0) : ctrlMispredict_i;
    end
  end

  task automatic step(input bit r, input bit v, input logic [5:0] c, input bit m, input logic [31:0] vec);
    @(posedge clock);
    #1;
    reset = r;
    dispValid_i = v;
    cntInstIssueQ_i = c;
    ctrlMispredict_i = m;
    mispredictVector_i = vec;
    @(negedge clock);
    #1;
  endtask

  task automatic chk_slots(input string tag, input int x0, x1, x2, x3, input logic [3:0] v);
    chk({tag, "_e0"}, a_e[0], x0);
    chk({tag, "_e1"}, a_e[1], x1);
    chk({tag, "_e2"}, a_e[2], x2);
    chk({tag, "_e3"}, a_e[3], x3);
    chk({tag, "_v"}, a_v, v);
  endtask

  initial begin
    int cs[4] = '{27, 28, 29, 32};
    bit bs[4] = '{1, 1, 0, 0};
    @(negedge clock);
    #1;
    chk("rst_ready", dispReady_o, 0);
    chk("rst_ber", backEndReady_o, 0);
    step(0, 1, 0, 0, 0);
    chk("first_ready", dispReady_o, 1);
    chk("first_ber", backEndReady_o, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, cs[i], 0, 0);
      chk($sformatf("sweep_%0d", cs[i]), backEndReady_o, bs[i]);
    end
    step(0, 1, 0, 1, 32'h8000_0F03);
    chk("mis_ber", backEndReady_o, 0);
    step(0, 1, 0, 0, 0);
    chk("rec1_busy", recoverBusy_o, 1);
    chk("rec1_ber", backEndReady_o, 0);
    chk_slots("rec1", 0, 1, 8, 9, 4'hF);
    step(0, 1, 0, 0, 0);
    chk("rec2_busy", recoverBusy_o, 1);
    chk_slots("rec2", 10, 11, 31, 0, 4'h7);
    step(0, 1, 0, 0, 0);
    chk("rec_done", recoverBusy_o, 0);
    chk("rec_done_ber", backEndReady_o, 1);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    chk("empty_busy", recoverBusy_o, 1);
    chk("empty_v", a_v, 0);
    step(0, 1, 0, 0, 0);
    chk("empty_done", recoverBusy_o, 0);
    step(0, 1, 0, 1, 32'h8000_0F03);
    step(0, 1, 0, 1, 32'h0001_0000);
    chk_slots("mis2a", 0, 1, 8, 9, 4'hF);
    step(0, 1, 0, 0, 0);
    chk_slots("mis2b", 10, 11, 16, 31, 4'hF);
    step(0, 1, 0, 0, 0);
    chk("mis2_done", recoverBusy_o, 0);
`ifdef IQ_STALL_CNT_EN
    repeat (70000) step(0, 1, 30, 0, 0);
    chk("stall_sat", stallCount_o, 16'hFFFF);
`endif
    step(0, 1, 0, 1, 32'hFFFF_FFFF);
    step(0, 1, 0, 0, 0);
    chk("mid_busy", recoverBusy_o, 1);
    step(1, 1, 0, 0, 0);
    chk("mid_rst_busy", recoverBusy_o, 0);
    chk("mid_rst_v", a_v, 0);
    chk("mid_rst_stall", stallCount_o, 0);
    step(0, 1, 0, 0, 0);
    chk("mid_rel_busy", recoverBusy_o, 0);
    repeat (3000) begin
      logic [31:0] vec;
      vec = ($urandom % 4 == 0) ? 32'h0 : ($urandom & $urandom);
      step($urandom % 300 == 0, $urandom % 2, 6'($urandom_range(0, 32)), $urandom % 6 == 0, vec);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/iq_alloc_ctrl.md
# iq_alloc_ctrl

Allocation and recovery controller for the issue-queue free list. Sits between Dispatch and the issue-queue free list: it decides each cycle whether a dispatch bundle may claim issue-queue entries, producing the free list's `backEndReady` input. After a control mispredict, a recovery state machine walks the squashed-entry mask and returns squashed entries to the free list, up to four per cycle, while dispatch is held off.

## Interface
- `SIZE_ISSUEQ`, 32, number of issue-queue entries.
- `SIZE_ISSUEQ_LOG`, 5, log2(`SIZE_ISSUEQ`).
- `DISPATCH_WIDTH`, 4, number of entries claimed per accepted bundle.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous reset, active-high.
- `dispValid_i`  in  1  Dispatch presents a bundle this cycle.
- `dispReady_o`  out  1  bundle may be accepted this cycle.
- `cntInstIssueQ_i`  in  `SIZE_ISSUEQ_LOG+1`  occupancy count from the free list.
- `ctrlMispredict_i`  in  1  mispredict pulse from Writeback.
- `mispredictVector_i`  in  `SIZE_ISSUEQ`  entries squashed by this mispredict.
- `backEndReady_o`  out  1  bundle accepted; drives the free list's head advance.
- `reclaimEntry0_o`..`reclaimEntry3_o`  out  `SIZE_ISSUEQ_LOG` each  squashed entries returned this cycle.
- `reclaimValid0_o`..`reclaimValid3_o`  out  1 each  matching valids.
- `recoverBusy_o`  out  1  recovery in progress.
- `stallCount_o`  out  16  dispatch stall counter; see Configuration.

## Operation
The controller has two states, RUN and RECOVER, and one register, `squashMask[SIZE_ISSUEQ-1:0]`.

- **Space check:** `space = (cntInstIssueQ_i <= SIZE_ISSUEQ - DISPATCH_WIDTH)`, compared unsigned in `SIZE_ISSUEQ_LOG+1` bits.
- **RUN outputs:**
  - `dispReady_o = space & ~ctrlMispredict_i`.
  - `backEndReady_o = dispValid_i & dispReady_o`.
  - All `reclaimValid*_o` = 0; `recoverBusy_o` = 0.
- **RUN, mispredict:** when `ctrlMispredict_i` = 1, latch `squashMask <= mispredictVector_i` and go to RECOVER. The mispredict blocks acceptance in the same cycle.
- **RECOVER outputs:**
  - `dispReady_o` = 0, `backEndReady_o` = 0, `recoverBusy_o` = 1.
  - Select the lowest-indexed set bits of `squashMask`, up to four. Drive them on `reclaimEntry0_o`..`reclaimEntry3_o` in ascending index order, valids packed from slot 0.
  - Unused slots have valid = 0 and entry = 0.
- **RECOVER, mask update:** `squashMask_next = (squashMask & ~selected) | (ctrlMispredict_i ? mispredictVector_i : 0)`.
- **RECOVER, exit:** go to RUN when `squashMask_next` == 0.
- **Empty mispredict vector:** RECOVER lasts exactly one cycle with no valids.
- **Duplicate bits:** a new mispredict in RECOVER whose vector contains an entry being reclaimed this cycle re-sets that bit, and the entry is reclaimed again. The upstream guarantees this does not happen; the controller does not filter it.
- **Reset mid-recovery:** state goes to RUN and `squashMask` clears. Pending reclaims are dropped, because the free list resets in the same cycle.

## Timing
- **Reset values:**
  - State = RUN, `squashMask` = 0, `stallCount_o` = 0.
  - While `reset` is high, all outputs are 0, including `dispReady_o` and `backEndReady_o`.
- **Dispatch handshake:** `dispReady_o` and `backEndReady_o` are combinational from current state and inputs. There is zero-cycle acceptance latency.
- **Recovery latency:** the mispredict is seen in cycle N, RECOVER is entered at N+1, and the first reclaim is valid at N+1. With k squashed bits, RECOVER occupies max(1, ceil(k/4)) cycles, and RUN resumes with `dispReady_o` possible on the following cycle.
- **Full boundary:**
  - At `cntInstIssueQ_i` = 28 (defaults), `dispReady_o` = 1.
  - At 29, `dispReady_o` = 0.
  - A value of 32 is legal and also gives 0.

## Configuration
- **`IQ_STALL_CNT_EN` defined:**
  - `stallCount_o` is a 16-bit register.
  - It increments each cycle with `dispValid_i` = 1 and `dispReady_o` = 0, in RUN or RECOVER.
  - It saturates at 0xFFFF and clears only on reset.
- **`IQ_STALL_CNT_EN` undefined:** `stallCount_o` is tied to 0 and no counter flops are built. The port exists in both builds.

## Test plan
- Release reset, `cntInstIssueQ_i` = 0, `dispValid_i` = 1 -> `dispReady_o` = 1 and `backEndReady_o` = 1 in the first cycle after reset; both are 0 while reset is high.
- Sweep `cntInstIssueQ_i` 27, 28, 29, 32 with `dispValid_i` = 1 -> `backEndReady_o` = 1, 1, 0, 0.
- Mispredict with vector 0x8000_0F03 (7 bits) -> RECOVER for 2 cycles:
  - cycle 1 reclaims 0, 1, 8, 9;
  - cycle 2 reclaims 10, 11, 31 with `reclaimValid3_o` = 0;
  - RUN in the next cycle, and `backEndReady_o` = 0 throughout.
- Mispredict with vector 0 -> exactly one RECOVER cycle, all valids 0, `recoverBusy_o` = 1 for one cycle.
- Second mispredict, vector 0x0001_0000, during cycle 1 of the 7-bit case above -> cycle 2 reclaims 10, 11, 16, 31; RUN follows.
- With `IQ_STALL_CNT_EN`: hold `dispValid_i` = 1 and `cntInstIssueQ_i` = 30 for 70000 cycles -> `stallCount_o` = 0xFFFF. Assert `reset` mid-recovery -> `squashMask` and `stallCount_o` clear immediately and all reclaim valids drop.
